// File: rtl/alu_pkg.sv
// Shared opcode and FSM state types for the alu_muldiv block.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_XOR   = 4'b0100,
        OP_NOR   = 4'b0101,
        OP_SUB   = 4'b0110,
        OP_SLT   = 4'b0111,
        OP_MULT  = 4'b1000,
        OP_MULTU = 4'b1001,
        OP_DIV   = 4'b1010,
        OP_DIVU  = 4'b1011,
        OP_MFHI  = 4'b1100,
        OP_MFLO  = 4'b1101,
        OP_SLTU  = 4'b1110
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Bit-serial multiply (shift-add) and restoring divide on operand magnitudes,
// with sign fix-up applied to the final-iteration values presented on o_hi/o_lo.
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,      // [1]=divide, [0]=unsigned
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] r_dvd;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div0;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_hi_nx;
    logic [WIDTH-1:0] w_lo_nx;
    logic [2*WIDTH-1:0] w_prod;

    assign w_a_neg = ~i_op[0] & i_a[WIDTH-1];
    assign w_b_neg = ~i_op[0] & i_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -i_a : i_a;
    assign w_b_mag = w_b_neg ? -i_b : i_b;

    // Multiply: HI accumulates the partial product, LO shifts out multiplier bits.
    assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mag} : '0);

    // Divide: HI is the partial remainder, LO shifts dividend out and quotient in.
    assign w_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_mag};
    assign w_ge    = ~w_trial[WIDTH];

    assign w_hi_nx = r_is_div ? (w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0])
                              : w_sum[WIDTH:1];
    assign w_lo_nx = r_is_div ? {r_lo[WIDTH-2:0], w_ge}
                              : {w_sum[0], r_lo[WIDTH-1:1]};
    assign w_prod  = {w_hi_nx, w_lo_nx};

    assign o_done = (r_cnt == CNT_W'(1));

    always_comb begin
        o_hi = w_hi_nx;
        o_lo = w_lo_nx;
        if (!r_is_div) begin
            {o_hi, o_lo} = r_neg_q ? -w_prod : w_prod;
        end else if (r_div0) begin
            o_hi = r_dvd;
            o_lo = '1;
        end else begin
            o_hi = r_neg_r ? -w_hi_nx : w_hi_nx;
            o_lo = r_neg_q ? -w_lo_nx : w_lo_nx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_mag    <= '0;
            r_dvd    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
        end else if (i_start) begin
            r_cnt    <= CNT_W'(WIDTH);
            r_hi     <= '0;
            r_lo     <= i_op[1] ? w_a_mag : w_b_mag;
            r_mag    <= i_op[1] ? w_b_mag : w_a_mag;
            r_dvd    <= i_a;
            r_is_div <= i_op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div0   <= (i_b == '0);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
            r_hi  <= w_hi_nx;
            r_lo  <= w_lo_nx;
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Registered MIPS ALU with iterative mult/div into HI/LO and a valid/ready issue port.
// Optional macro ALU_OVERFLOW_EN adds a registered signed add/sub overflow output.
//
// state   | meaning
// IDLE    | ready; single-cycle ops complete here
// MUL     | multiply iterating
// DIV     | divide iterating
// DONE    | HI/LO written, out_valid asserted
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_operation,
    input  logic [WIDTH-1:0] input_data1,
    input  logic [WIDTH-1:0] input_data2,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    alu_state_e       r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    alu_op_e          w_op;
    logic [WIDTH-1:0] w_add;
    logic [WIDTH-1:0] w_sub;
    logic             w_slt;
    logic             w_sltu;
    logic [WIDTH-1:0] w_alu;
    logic             w_accept;
    logic             w_start;
    logic             w_done;
    logic [WIDTH-1:0] w_it_hi;
    logic [WIDTH-1:0] w_it_lo;

    assign w_op     = alu_op_e'(alu_operation);
    assign w_add    = input_data1 + input_data2;
    assign w_sub    = input_data1 - input_data2;
    assign w_slt    = $signed(input_data1) < $signed(input_data2);
    assign w_sltu   = input_data1 < input_data2;
    assign w_accept = in_valid && (r_state == ST_IDLE);
    assign w_start  = w_accept && (alu_operation[3:2] == 2'b10);

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_AND:  w_alu = input_data1 & input_data2;
            OP_OR:   w_alu = input_data1 | input_data2;
            OP_ADD:  w_alu = w_add;
            OP_SUB:  w_alu = w_sub;
            OP_XOR:  w_alu = input_data1 ^ input_data2;
            OP_NOR:  w_alu = ~(input_data1 | input_data2);
            OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, w_slt};
            OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, w_sltu};
            OP_MFHI: w_alu = r_hi;
            OP_MFLO: w_alu = r_lo;
            default: w_alu = '0;
        endcase
    end

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .reset_n (reset_n),
        .i_start (w_start),
        .i_op    (alu_operation[1:0]),
        .i_a     (input_data1),
        .i_b     (input_data2),
        .o_done  (w_done),
        .o_hi    (w_it_hi),
        .o_lo    (w_it_lo)
    );

`ifdef ALU_OVERFLOW_EN
    logic r_ovf;
    logic w_ovf;

    assign w_ovf = (w_op == OP_ADD) ? ((input_data1[WIDTH-1] == input_data2[WIDTH-1]) &&
                                       (w_add[WIDTH-1] != input_data1[WIDTH-1])) :
                   (w_op == OP_SUB) ? ((input_data1[WIDTH-1] != input_data2[WIDTH-1]) &&
                                       (w_sub[WIDTH-1] != input_data1[WIDTH-1])) : 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
        end else if (w_accept && !w_start) begin
            r_ovf <= w_ovf;
        end else if (w_done && (r_state == ST_MUL || r_state == ST_DIV)) begin
            r_ovf <= 1'b0;
        end
    end

    assign overflow = r_ovf;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_start) begin
                            r_state <= alu_operation[1] ? ST_DIV : ST_MUL;
                        end else begin
                            r_result    <= w_alu;
                            r_zero      <= (w_alu == '0);
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (w_done) begin
                        r_state     <= ST_DONE;
                        r_hi        <= w_it_hi;
                        r_lo        <= w_it_lo;
                        r_result    <= w_it_lo;
                        r_zero      <= (w_it_lo == '0);
                        r_out_valid <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == ST_IDLE);
    assign busy       = (r_state == ST_MUL) || (r_state == ST_DIV);
    assign out_valid  = r_out_valid;
    assign alu_result = r_result;
    assign zero       = r_zero;
    assign hi         = r_hi;
    assign lo         = r_lo;

endmodule
